mips_mem_responder: RTL and testbench

//  Memory-side responder for the MIPS CPU data/instruction handshake interface.

---
 rtl/mips_mem_responder.sv | 138 +++++++++++++
 tb/tb_mips_mem_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the MIPS CPU request/response handshake.
// Services one request at a time from an internal word-addressed RAM.
// Writes complete at the transfer edge. Reads return after a programmable
// wait, which lets the CPU stall paths be exercised.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | accepting requests; writes commit in place, reads go to WAIT
// WAIT   | read latched, down-counting the programmed latency
// RESP   | read data presented, held until the CPU acknowledges it
module mips_mem_responder #(
  parameter int    MEM_WORDS = 1024,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        sys_clk,
  input  logic        sys_reset_n,
  input  logic        mem_req_valid,
  output logic        mem_req_ack,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  input  logic        rdata_ack
);

  localparam int ABITS = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      mem [MEM_WORDS];
  logic [ABITS-1:0] req_idx;
  logic [ABITS-1:0] idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ack_d;
  logic             valid_d;
  logic             load_rdata;
  logic             mem_we;
  logic             transfer;

  // Byte offset and bits above the RAM window do not select a word.
  logic unused_addr;
  assign unused_addr = ^{mem_addr[31:ABITS+2], mem_addr[1:0]};

  assign req_idx  = mem_addr[ABITS+1:2];
  assign transfer = mem_req_valid & mem_req_ack;

  // State, counter, latched index and registered handshake outputs.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      mem_req_ack <= 1'b1;
      rdata_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      mem_req_ack <= ack_d;
      rdata_valid <= valid_d;
    end
  end

  // Read data register; keeps its last value after the response completes.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      rdata <= 32'd0;
    end else if (load_rdata) begin
      rdata <= mem[idx_q];
    end
  end

  // RAM byte-lane writes; contents survive reset.
  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wstrb[i]) mem[req_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    ack_d      = mem_req_ack;
    valid_d    = rdata_valid;
    load_rdata = 1'b0;
    mem_we     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          if (mem_wen) begin
            mem_we = 1'b1;
          end else begin
            idx_d   = req_idx;
            cnt_d   = LAT_CNT;
            ack_d   = 1'b0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          load_rdata = 1'b1;
          valid_d    = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rdata_ack) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Randomized scoreboard bench for mips_mem_responder.
// Driver issues requests and pushes expected read responses; a separate
// monitor pops them when the DUT raises rdata_valid.
module tb_mips_mem_responder;

  localparam int MEM_WORDS = 1024;
  localparam int LAT       = 2;
  localparam int ABITS     = $clog2(MEM_WORDS);

  logic        sys_clk = 1'b0;
  logic        sys_reset_n;
  logic        mem_req_valid;
  logic        mem_req_ack;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        rdata_ack;

  mips_mem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LAT), .INIT_FILE("")) dut (
    .sys_clk      (sys_clk),
    .sys_reset_n  (sys_reset_n),
    .mem_req_valid(mem_req_valid),
    .mem_req_ack  (mem_req_ack),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .rdata_ack    (rdata_ack)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] data;
    int          edge_no;
  } exp_t;

  logic [31:0] ref_mem [MEM_WORDS];
  exp_t        sb_q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic finish_sim();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  // Monitor: pop and compare on each new response, check stability while held.
  logic        prev_valid = 1'b0;
  logic [31:0] held;
  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (rdata_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_resp: got rdata_valid=1 expected none pending (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          chk("rdata", rdata, e.data);
          chk("latency", cyc, e.edge_no + LAT + 1);
        end
        held = rdata;
      end else if (rdata_valid) begin
        chk("rdata_hold", rdata, held);
        chk("req_ack_low_in_resp", {31'd0, mem_req_ack}, 32'd0);
      end
      prev_valid = rdata_valid;
    end
  end

  function automatic logic [ABITS-1:0] widx(input logic [31:0] a);
    return a[ABITS+1:2];
  endfunction

  task automatic noise();
    mem_req_valid = 1'($urandom_range(0, 1));
    mem_wen       = 1'($urandom_range(0, 1));
    mem_addr      = $urandom();
    mem_wdata     = $urandom();
    mem_wstrb     = 4'($urandom_range(0, 15));
  endtask

  task automatic op_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge sys_clk);
    chk("req_ack_idle", {31'd0, mem_req_ack}, 32'd1);
    mem_req_valid = 1'b1;
    mem_wen       = 1'b1;
    mem_addr      = a;
    mem_wdata     = d;
    mem_wstrb     = s;
    rdata_ack     = 1'($urandom_range(0, 1));
    @(posedge sys_clk);
    for (int i = 0; i < 4; i++)
      if (s[i]) ref_mem[widx(a)][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic op_read(input logic [31:0] a, input int hold);
    exp_t e;
    int   n;
    @(negedge sys_clk);
    chk("req_ack_idle", {31'd0, mem_req_ack}, 32'd1);
    mem_req_valid = 1'b1;
    mem_wen       = 1'b0;
    mem_addr      = a;
    mem_wdata     = $urandom();
    mem_wstrb     = 4'($urandom_range(0, 15));
    rdata_ack     = 1'($urandom_range(0, 1));
    e.data        = ref_mem[widx(a)];
    e.edge_no     = cyc + 1;
    sb_q.push_back(e);
    @(posedge sys_clk);
    n = 0;
    forever begin
      @(negedge sys_clk);
      if (rdata_valid) break;
      noise();
      rdata_ack = 1'($urandom_range(0, 1));
      n++;
      if (n > 40) begin
        n_vec++;
        n_err++;
        $display("FAIL resp_timeout: got no rdata_valid expected within %0d cycles", 40);
        finish_sim();
      end
    end
    rdata_ack = 1'b0;
    repeat (hold) begin
      noise();
      @(negedge sys_clk);
    end
    rdata_ack     = 1'b1;
    mem_req_valid = 1'b0;
    @(negedge sys_clk);
    rdata_ack = 1'b0;
    chk("req_ack_after_resp", {31'd0, mem_req_ack}, 32'd1);
    chk("valid_after_resp", {31'd0, rdata_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] rst_addr;
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    sys_reset_n   = 1'b0;
    mem_req_valid = 1'b0;
    mem_wen       = 1'b0;
    mem_addr      = 32'd0;
    mem_wdata     = 32'd0;
    mem_wstrb     = 4'd0;
    rdata_ack     = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_reset_n = 1'b1;
    @(negedge sys_clk);
    chk("reset_req_ack", {31'd0, mem_req_ack}, 32'd1);
    chk("reset_valid", {31'd0, rdata_valid}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);

    // Fill the whole RAM so every later read has a known model value.
    for (int i = 0; i < MEM_WORDS; i++) op_write(32'(i * 4), $urandom(), 4'hF);

    op_write(32'h10, 32'hDEADBEEF, 4'hF);
    op_read(32'h10, 0);
    op_write(32'h10, 32'h000000AA, 4'b0001);
    op_read(32'h10, 0);
    chk("merge_model", ref_mem[4], 32'hDEADBEAA);
    op_read(32'h10, 5);

    op_write(32'h0, 32'h11111111, 4'hF);
    op_write(32'(MEM_WORDS * 4), 32'h22222222, 4'hF);
    op_write(32'h8, 32'h33333333, 4'hF);
    op_write(32'hC, 32'h44444444, 4'b0000);
    op_read(32'h0, 2);
    op_read(32'hC, 1);

    // Reset during WAIT abandons the read; RAM keeps earlier writes.
    op_write(32'h40, 32'hCAFEF00D, 4'hF);
    op_read(32'h40, 0);
    @(negedge sys_clk);
    mem_req_valid = 1'b1;
    mem_wen       = 1'b0;
    mem_addr      = 32'h10;
    @(posedge sys_clk);
    @(negedge sys_clk);
    mem_req_valid = 1'b0;
    #2 sys_reset_n = 1'b0;
    #1;
    chk("midwait_rst_req_ack", {31'd0, mem_req_ack}, 32'd1);
    chk("midwait_rst_valid", {31'd0, rdata_valid}, 32'd0);
    chk("midwait_rst_rdata", rdata, 32'd0);
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
    @(negedge sys_clk);
    chk("post_rst_valid", {31'd0, rdata_valid}, 32'd0);
    op_read(32'h40, 1);

    for (int k = 0; k < 300; k++) begin
      a = $urandom();
      if ($urandom_range(0, 9) < 6) op_write(a, $urandom(), 4'($urandom_range(0, 15)));
      else                           op_read(a, $urandom_range(0, 5));
    end

    @(negedge sys_clk);
    mem_req_valid = 1'b0;
    repeat (4) @(negedge sys_clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    finish_sim();
  end

endmodule
